// File: rtl/booth_seq_pkg.sv
// Shared encodings for the radix-2 Booth control sequencer.
// State codes are 3-bit binary; a_sel picks the A register's load source.
package booth_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t LOAD_M = 3'd1;
  localparam state_t LOAD_Q = 3'd2;
  localparam state_t ARITH  = 3'd3;
  localparam state_t SHIFT  = 3'd4;
  localparam state_t OUT_A  = 3'd5;
  localparam state_t OUT_Q  = 3'd6;

  localparam logic SEL_ADDER = 1'b0;
  localparam logic SEL_ZERO  = 1'b1;

endpackage

// File: rtl/booth_seq_iter_counter.sv
// Iteration counter: synchronous clear, increment enable, saturates at width.
// last_o flags that the next increment reaches width.
module iter_counter #(
  parameter int width     = 8,
  parameter int cnt_width = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam logic [cnt_width:0] WIDTH_C = (cnt_width + 1)'(width);

  logic [cnt_width-1:0] cnt_q;
  logic [cnt_width-1:0] cnt_d;
  logic [cnt_width:0]   cnt_ext;
  logic [cnt_width:0]   cnt_nxt_ext;
  logic                 at_max;

  assign cnt_ext     = {1'b0, cnt_q};
  assign cnt_nxt_ext = cnt_ext + (cnt_width + 1)'(1);
  assign at_max      = (cnt_ext == WIDTH_C);
  assign last_o      = (cnt_nxt_ext == WIDTH_C);

  // Holding at width keeps the count from ever wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max) begin
      cnt_d = cnt_q + cnt_width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/booth_seq.sv
// Radix-2 Booth multiply sequencer: drives load/shift/adder/bus enables only.
// Keeps Booth's Q[-1] bit locally; data bits never pass through this block.
module booth_seq
  import booth_seq_pkg::*;
#(
  parameter int width     = 8,
  parameter int cnt_width = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  output logic busy,
  output logic done,
  output logic ld_m,
  output logic ld_q,
  output logic ld_a,
  output logic a_sel,
  output logic sub,
  output logic shr_aq,
  output logic out_a,
  output logic out_q
);

  state_t state_q;
  state_t state_d;
  logic   qm1_q;
  logic   qm1_d;
  logic   cnt_last;

  iter_counter #(
    .width     (width),
    .cnt_width (cnt_width)
  ) u_iter_counter (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (state_q == LOAD_Q),
    .inc_i  (state_q == SHIFT),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      qm1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qm1_q   <= qm1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    qm1_d   = qm1_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD_M;
      LOAD_M:  state_d = LOAD_Q;
      LOAD_Q: begin
        state_d = ARITH;
        qm1_d   = 1'b0;
      end
      ARITH:   state_d = SHIFT;
      SHIFT: begin
        // q0 is sampled before the shift lands, so it becomes the new Q[-1].
        qm1_d   = q0;
        state_d = cnt_last ? OUT_A : ARITH;
      end
      OUT_A:   state_d = OUT_Q;
      OUT_Q:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    done   = 1'b0;
    ld_m   = 1'b0;
    ld_q   = 1'b0;
    ld_a   = 1'b0;
    a_sel  = SEL_ADDER;
    sub    = 1'b0;
    shr_aq = 1'b0;
    out_a  = 1'b0;
    out_q  = 1'b0;
    case (state_q)
      LOAD_M: ld_m = 1'b1;
      LOAD_Q: begin
        ld_q  = 1'b1;
        ld_a  = 1'b1;
        a_sel = SEL_ZERO;
      end
      ARITH: begin
        case ({q0, qm1_q})
          2'b10: begin
            ld_a = 1'b1;
            sub  = 1'b1;
          end
          2'b01:   ld_a = 1'b1;
          default: ld_a = 1'b0;
        endcase
      end
      SHIFT:  shr_aq = 1'b1;
      OUT_A:  out_a  = 1'b1;
      OUT_Q: begin
        out_q = 1'b1;
        done  = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule
